mac_vector_ctrl: RTL and testbench

Parametrised operand-entry and sequencing controller for the FP MAC datapath. It captures two DEPTH-entry operand vectors (A, B) one word per button press, stores them in internal register files, then streams the pairs into the external MAC unit over a valid/ready handshake. It latches the final result and can re-run on the stored vectors. It sits between the keypad scanner, the next-state button, the 7-segment display path and the MAC wrapper, and replaces the fixed 8-entry, free-running top-level FSM.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/btn_sync_edge.sv | 37 +++
 rtl/mac_vector_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mac_vector_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC vector controller.
//   - external 2-bit state codes used on the Arduino link
//   - internal controller states (RUN is split into clear/stream/wait
//     phases and DONE; all of them report the RUN code externally)
//   - ext_code(): internal state -> external 2-bit code
package mac_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD_A = 2'b01,
        ST_LOAD_B = 2'b10,
        ST_RUN    = 2'b11
    } st_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RUN_CLR,
        S_RUN_STREAM,
        S_RUN_WAIT,
        S_DONE
    } ctrl_e;

    // DONE shares the RUN code; the link tells them apart by idx = DEPTH-1.
    function automatic st_code_e ext_code(input ctrl_e s);
        st_code_e c;
        case (s)
            S_IDLE:   c = ST_IDLE;
            S_LOAD_A: c = ST_LOAD_A;
            S_LOAD_B: c = ST_LOAD_B;
            default:  c = ST_RUN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus falling-edge detector for an
// active-low, asynchronous button. No debounce here.
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_btn_n   raw button, active-low, asynchronous to i_clk
//   o_press   one-cycle pulse, high 3 clocks after the button falls
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    logic r_sync_p0;
    logic r_sync_p1;
    logic r_prev_p2;
    logic r_press;

    // Flops reset to 1 (button released) so reset release never fakes a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
            r_prev_p2 <= 1'b1;
            r_press   <= 1'b0;
        end else begin
            r_sync_p0 <= i_btn_n;
            r_sync_p1 <= r_sync_p0;
            r_prev_p2 <= r_sync_p1;
            r_press   <= r_prev_p2 & ~r_sync_p1;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/mac_vector_ctrl.sv
// mac_vector_ctrl: operand-entry and sequencing controller for the FP MAC.
// Captures DEPTH-entry vectors A and B one keypad word per button press,
// then streams (A[i], B[i]) pairs to the MAC over valid/ready, latches the
// final result and optionally re-runs on the stored vectors.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_ns_button              raw next-state button (active-low, async)
//   i_rerun_en               in DONE: 1 = press re-runs, 0 = press -> IDLE
//   i_key_valid, i_key_data  keypad word strobe
//   o_mac_clr                one-cycle accumulator clear on RUN entry
//   o_mac_valid, i_mac_ready, o_mac_a, o_mac_b   operand pair handshake
//   i_mac_res_valid, i_mac_result                MAC final result
//   o_key_en                 scanner enable (LOAD_A / LOAD_B)
//   o_disp_data, o_disp_blank  hex display word / blank
//   o_state_code             {2-bit state code, idx}
//   o_done                   high in DONE
module mac_vector_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ns_button,
    input  logic                i_rerun_en,
    input  logic                i_key_valid,
    input  logic [DATA_W-1:0]   i_key_data,
    output logic                o_mac_clr,
    output logic                o_mac_valid,
    input  logic                i_mac_ready,
    output logic [DATA_W-1:0]   o_mac_a,
    output logic [DATA_W-1:0]   o_mac_b,
    input  logic                i_mac_res_valid,
    input  logic [DATA_W-1:0]   i_mac_result,
    output logic                o_key_en,
    output logic [DATA_W-1:0]   o_disp_data,
    output logic                o_disp_blank,
    output logic [2+ADDR_W-1:0] o_state_code,
    output logic                o_done
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    ctrl_e             r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_a [DEPTH];
    logic [DATA_W-1:0] r_b [DEPTH];
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_res;

    logic              w_press;
    logic              w_wr_a;
    logic              w_wr_b;
    logic              w_key_clr;
    logic              w_res_latch;
    logic              w_in_load;
    logic [DATA_W-1:0] w_key_wdata;

    btn_sync_edge u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn_n (i_ns_button),
        .o_press (w_press)
    );

    assign w_in_load   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    // A key arriving in the same cycle as the press is the word written.
    assign w_key_wdata = i_key_valid ? i_key_data : r_key;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_wr_a       = 1'b0;
        w_wr_b       = 1'b0;
        w_key_clr    = 1'b0;
        w_res_latch  = 1'b0;
        o_mac_clr    = 1'b0;
        o_mac_valid  = 1'b0;
        o_key_en     = 1'b0;
        o_disp_data  = '0;
        o_disp_blank = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_disp_blank = 1'b1;
                if (w_press) begin
                    w_state_nxt = S_LOAD_A;
                    w_idx_nxt   = '0;
                    w_key_clr   = 1'b1;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                o_key_en    = 1'b1;
                o_disp_data = r_key;
                if (w_press) begin
                    w_wr_a    = (r_state == S_LOAD_A);
                    w_wr_b    = (r_state == S_LOAD_B);
                    w_key_clr = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = (r_state == S_LOAD_A) ? S_LOAD_B : S_RUN_CLR;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end
            end
            S_RUN_CLR: begin
                o_mac_clr   = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = S_RUN_STREAM;
            end
            S_RUN_STREAM: begin
                o_mac_valid = 1'b1;
                if (i_mac_ready) begin
                    // idx parks at DEPTH-1 after the last pair, which is
                    // also the value DONE must report.
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_RUN_WAIT;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end
            end
            S_RUN_WAIT: begin
                if (i_mac_res_valid) begin
                    w_res_latch = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                o_disp_data = r_res;
                if (w_press) begin
                    w_state_nxt = i_rerun_en ? S_RUN_CLR : S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_key <= '0;
            r_res <= '0;
        end else begin
            if (w_wr_a) r_a[r_idx] <= w_key_wdata;
            if (w_wr_b) r_b[r_idx] <= w_key_wdata;
            if (w_key_clr) begin
                r_key <= '0;
            end else if (i_key_valid && w_in_load) begin
                r_key <= i_key_data;
            end
            if (w_res_latch) r_res <= i_mac_result;
        end
    end

    assign o_mac_a      = r_a[r_idx];
    assign o_mac_b      = r_b[r_idx];
    assign o_state_code = {ext_code(r_state), r_idx};

endmodule

// File: tb/tb_mac_vector_ctrl.sv
module tb_mac_vector_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ns_button = 1'b1;
    logic                rerun_en = 1'b0;
    logic                key_valid = 1'b0;
    logic [DATA_W-1:0]   key_data = '0;
    logic                mac_ready = 1'b0;
    logic                mac_res_valid = 1'b0;
    logic [DATA_W-1:0]   mac_result = '0;
    logic                mac_clr;
    logic                mac_valid;
    logic [DATA_W-1:0]   mac_a;
    logic [DATA_W-1:0]   mac_b;
    logic                key_en;
    logic [DATA_W-1:0]   disp_data;
    logic                disp_blank;
    logic [2+ADDR_W-1:0] state_code;
    logic                done;

    mac_vector_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ns_button     (ns_button),
        .i_rerun_en      (rerun_en),
        .i_key_valid     (key_valid),
        .i_key_data      (key_data),
        .o_mac_clr       (mac_clr),
        .o_mac_valid     (mac_valid),
        .i_mac_ready     (mac_ready),
        .o_mac_a         (mac_a),
        .o_mac_b         (mac_b),
        .i_mac_res_valid (mac_res_valid),
        .i_mac_result    (mac_result),
        .o_key_en        (key_en),
        .o_disp_data     (disp_data),
        .o_disp_blank    (disp_blank),
        .o_state_code    (state_code),
        .o_done          (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Reference model: the vectors the operator entered.
    logic [DATA_W-1:0] mA [DEPTH];
    logic [DATA_W-1:0] mB [DEPTH];
    logic [31:0]       got_q [$];
    int n_clr, n_stall_bad, span, clr_gap, load_bad;

    // State code as seen on the link: {state, idx}; 0=IDLE 1=LOAD_A 2=LOAD_B 3=RUN/DONE.
    function automatic logic [4:0] code(input int st, input int idx);
        return {st[1:0], idx[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_in(input logic [DATA_W-1:0] v);
        key_valid = 1'b1;
        key_data  = v;
        tick();
        key_valid = 1'b0;
    endtask

    // Returns one clock after the press pulse, i.e. once the press took effect.
    // With with_key the keypad strobe lands in the same cycle as the press pulse.
    task automatic press_btn(input bit with_key, input logic [DATA_W-1:0] kd);
        ns_button = 1'b1;
        repeat (3) tick();
        ns_button = 1'b0;
        repeat (3) tick();
        if (with_key) begin
            key_valid = 1'b1;
            key_data  = kd;
        end
        tick();
        key_valid = 1'b0;
        ns_button = 1'b1;
    endtask

    // Enters mA then mB starting from LOAD_A idx 0; counts unexpected state codes.
    task automatic load_vectors(input int byp_idx);
        logic [4:0] exp;
        load_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            key_in(mA[i]);
            press_btn(1'b0, '0);
            exp = (i == DEPTH - 1) ? code(2, 0) : code(1, i + 1);
            if (state_code !== exp) load_bad++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == byp_idx) begin
                key_in(~mB[i]);
                press_btn(1'b1, mB[i]);
            end else begin
                key_in(mB[i]);
                press_btn(1'b0, '0);
            end
            exp = (i == DEPTH - 1) ? code(3, 0) : code(2, i + 1);
            if (state_code !== exp) load_bad++;
        end
    endtask

    // Observes one RUN pass; cycle budget bounds the wait.
    task automatic run_stream(input bit rnd_ready);
        int first, clr_c;
        bit prev_stall;
        logic [31:0] prev_pair;
        got_q.delete();
        n_clr = 0; n_stall_bad = 0; span = 0;
        first = -1; clr_c = -1; prev_stall = 1'b0; prev_pair = '0;
        mac_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 400 && got_q.size() < DEPTH; c++) begin
            @(negedge clk);
            if (mac_clr) begin n_clr++; clr_c = c; end
            if (prev_stall && (mac_valid !== 1'b1 || {mac_a, mac_b} !== prev_pair)) n_stall_bad++;
            if (mac_valid && first < 0) first = c;
            prev_stall = mac_valid && !mac_ready;
            prev_pair  = {mac_a, mac_b};
            if (mac_valid && mac_ready) begin
                got_q.push_back({mac_a, mac_b});
                span = c - first + 1;
            end
            @(posedge clk);
            #1;
            mac_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        mac_ready = 1'b0;
        clr_gap = (first >= 0 && clr_c >= 0) ? first - clr_c : -1;
    endtask

    task automatic send_result(input logic [DATA_W-1:0] r);
        mac_result    = r;
        mac_res_valid = 1'b1;
        tick();
        mac_res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++; if (state_code !== 5'd0) begin errors++; $display("FAIL reset_state_code got %h exp 00", state_code); end
        tests++; if (mac_valid !== 1'b0) begin errors++; $display("FAIL reset_mac_valid got %b exp 0", mac_valid); end
        tests++; if (mac_clr !== 1'b0) begin errors++; $display("FAIL reset_mac_clr got %b exp 0", mac_clr); end
        tests++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (key_en !== 1'b0) begin errors++; $display("FAIL reset_key_en got %b exp 0", key_en); end
        tests++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL reset_disp_blank got %b exp 1", disp_blank); end
        tests++; if (disp_data !== 16'h0) begin errors++; $display("FAIL reset_disp_data got %h exp 0000", disp_data); end
        tests++; if ({mac_a, mac_b} !== 32'h0) begin errors++; $display("FAIL reset_operands got %h exp 0", {mac_a, mac_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_key_entry();
        ns_button = 1'b1;
        repeat (3) tick();
        ns_button = 1'b0;
        repeat (3) tick();
        tests++; if (state_code !== code(0, 0)) begin errors++; $display("FAIL press_latency_early got %h exp %h", state_code, code(0, 0)); end
        tick();
        ns_button = 1'b1;
        tests++; if (state_code !== code(1, 0)) begin errors++; $display("FAIL press_to_load_a got %h exp %h", state_code, code(1, 0)); end
        tests++; if (key_en !== 1'b1) begin errors++; $display("FAIL load_key_en got %b exp 1", key_en); end
        tests++; if (disp_data !== 16'h0) begin errors++; $display("FAIL load_disp_initial got %h exp 0000", disp_data); end
        tests++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL load_disp_blank got %b exp 0", disp_blank); end
        key_in(16'h3C00);
        tests++; if (disp_data !== 16'h3C00) begin errors++; $display("FAIL key_display got %h exp 3c00", disp_data); end
        for (int i = 0; i < DEPTH; i++) begin
            mA[i] = 16'(i + 1);
            mB[i] = 16'(16 * i);
        end
        load_vectors(-1);
        tests++; if (load_bad !== 0) begin errors++; $display("FAIL directed_load got %0d bad codes exp 0", load_bad); end
    endtask

    task automatic test_run_directed();
        run_stream(1'b0);
        tests++; if (n_clr !== 1) begin errors++; $display("FAIL run_clr_count got %0d exp 1", n_clr); end
        tests++; if (clr_gap !== 1) begin errors++; $display("FAIL run_clr_to_valid got %0d exp 1", clr_gap); end
        tests++; if (got_q.size() !== DEPTH) begin errors++; $display("FAIL run_pair_count got %0d exp %0d", got_q.size(), DEPTH); end
        tests++; if (span !== DEPTH) begin errors++; $display("FAIL run_consecutive got %0d cycles exp %0d", span, DEPTH); end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== {mA[i], mB[i]}) begin errors++; $display("FAIL run_pair[%0d] got %h exp %h", i, got_q[i], {mA[i], mB[i]}); end
        end
        tests++; if (mac_valid !== 1'b0) begin errors++; $display("FAIL run_valid_after got %b exp 0", mac_valid); end
        tests++; if (state_code !== code(3, DEPTH - 1) || done !== 1'b0) begin errors++; $display("FAIL run_wait got code %h done %b exp %h 0", state_code, done, code(3, DEPTH - 1)); end
        send_result(16'h1234);
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL done_flag got %b exp 1", done); end
        tests++; if (disp_data !== 16'h1234) begin errors++; $display("FAIL done_disp got %h exp 1234", disp_data); end
        tests++; if (state_code !== code(3, DEPTH - 1)) begin errors++; $display("FAIL done_code got %h exp %h", state_code, code(3, DEPTH - 1)); end
    endtask

    task automatic test_rerun_stall();
        logic [DATA_W-1:0] r;
        rerun_en  = 1'b1;
        mac_ready = 1'b0;
        press_btn(1'b0, '0);
        run_stream(1'b1);
        tests++; if (n_clr !== 1) begin errors++; $display("FAIL rerun_clr_count got %0d exp 1", n_clr); end
        tests++; if (n_stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", n_stall_bad); end
        tests++; if (got_q.size() !== DEPTH) begin errors++; $display("FAIL rerun_pair_count got %0d exp %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== {mA[i], mB[i]}) begin errors++; $display("FAIL rerun_pair[%0d] got %h exp %h", i, got_q[i], {mA[i], mB[i]}); end
        end
        r = 16'($urandom);
        send_result(r);
        tests++; if (done !== 1'b1 || disp_data !== r) begin errors++; $display("FAIL rerun_result got done %b disp %h exp 1 %h", done, disp_data, r); end
    endtask

    task automatic test_idle_return();
        rerun_en = 1'b0;
        press_btn(1'b0, '0);
        tests++; if (state_code !== code(0, 0)) begin errors++; $display("FAIL idle_return_code got %h exp 00", state_code); end
        tests++; if (disp_blank !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL idle_return_flags got blank %b done %b exp 1 0", disp_blank, done); end
        send_result(16'hDEAD);
        tick();
        tests++; if (state_code !== code(0, 0) || done !== 1'b0) begin errors++; $display("FAIL stray_result got code %h done %b exp 00 0", state_code, done); end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] r;
        press_btn(1'b0, '0);
        tests++; if (state_code !== code(1, 0)) begin errors++; $display("FAIL bypass_enter got %h exp %h", state_code, code(1, 0)); end
        for (int i = 0; i < DEPTH; i++) begin
            mA[i] = 16'($urandom);
            mB[i] = 16'($urandom);
        end
        mB[3] = 16'hABCD;
        load_vectors(3);
        tests++; if (load_bad !== 0) begin errors++; $display("FAIL bypass_load got %0d bad codes exp 0", load_bad); end
        run_stream(1'b1);
        tests++; if (got_q.size() !== DEPTH) begin errors++; $display("FAIL bypass_pair_count got %0d exp %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== {mA[i], mB[i]}) begin errors++; $display("FAIL bypass_pair[%0d] got %h exp %h", i, got_q[i], {mA[i], mB[i]}); end
        end
        r = 16'($urandom);
        send_result(r);
        tests++; if (disp_data !== r) begin errors++; $display("FAIL bypass_result got %h exp %h", disp_data, r); end
    endtask

    task automatic test_reset_midrun();
        rerun_en  = 1'b1;
        mac_ready = 1'b0;
        press_btn(1'b0, '0);
        mac_ready = 1'b1;
        repeat (4) tick();
        mac_ready = 1'b0;
        tick();
        tests++; if (mac_valid !== 1'b1 || state_code !== code(3, 3)) begin errors++; $display("FAIL midrun_pre got valid %b code %h exp 1 %h", mac_valid, state_code, code(3, 3)); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (mac_valid !== 1'b0) begin errors++; $display("FAIL async_valid_drop got %b exp 0", mac_valid); end
        tests++; if (state_code !== 5'd0 || disp_blank !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL async_reset_ctrl got code %h blank %b done %b exp 00 1 0", state_code, disp_blank, done); end
        tests++; if ({mac_a, mac_b} !== 32'h0) begin errors++; $display("FAIL async_reset_regfile got %h exp 0", {mac_a, mac_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        press_btn(1'b0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            mA[i] = 16'($urandom);
            mB[i] = 16'($urandom);
        end
        load_vectors(-1);
        tests++; if (load_bad !== 0) begin errors++; $display("FAIL reload got %0d bad codes exp 0", load_bad); end
        run_stream(1'b0);
        tests++; if (n_clr !== 1 || got_q.size() !== DEPTH) begin errors++; $display("FAIL reload_run got clr %0d pairs %0d exp 1 %0d", n_clr, got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== {mA[i], mB[i]}) begin errors++; $display("FAIL reload_pair[%0d] got %h exp %h", i, got_q[i], {mA[i], mB[i]}); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_key_entry();
        test_run_directed();
        test_rerun_stall();
        test_idle_return();
        test_bypass();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
